// File: rtl/clock_sequencer_if.sv
// Button/flag inputs and counter strobe outputs of the clock digit-chain sequencer.
// master drives buttons and max flags; slave is the sequencer.
interface clock_sequencer_if;
    logic       ena;
    logic       btn_mode;
    logic       btn_inc;
    logic       max_sec_u;
    logic       max_sec_t;
    logic       max_min_u;
    logic       max_min_t;
    logic       en_sec_u;
    logic       en_sec_t;
    logic       en_min_u;
    logic       en_min_t;
    logic       en_hr;
    logic       clr_sec;
    logic [1:0] mode;

    modport master (
        output ena, btn_mode, btn_inc, max_sec_u, max_sec_t, max_min_u, max_min_t,
        input  en_sec_u, en_sec_t, en_min_u, en_min_t, en_hr, clr_sec, mode
    );

    modport slave (
        input  ena, btn_mode, btn_inc, max_sec_u, max_sec_t, max_min_u, max_min_t,
        output en_sec_u, en_sec_t, en_min_u, en_min_t, en_hr, clr_sec, mode
    );
endinterface

// File: rtl/clock_sequencer.sv
// Clock digit-chain sequencer: 1 s prescaler, carry-rippled counter strobes, RUN/SET_MIN/SET_HR modes.
// Strobes are registered, one cycle after the tick or button edge; no backpressure, ena=0 freezes all.
module clock_sequencer #(
    parameter int CLK_DIV = 1000,
    parameter int DIV_W   = 10
) (
    input  logic               clk,
    input  logic               res,
    clock_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_MIN = 2'd1,
        SET_HR  = 2'd2
    } mode_e;

    localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(CLK_DIV - 1);

    mode_e            mode_q, mode_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             btn_mode_q, btn_mode_d;
    logic             btn_inc_q, btn_inc_d;
    logic             en_sec_u_q, en_sec_u_d;
    logic             en_sec_t_q, en_sec_t_d;
    logic             en_min_u_q, en_min_u_d;
    logic             en_min_t_q, en_min_t_d;
    logic             en_hr_q, en_hr_d;
    logic             clr_sec_q, clr_sec_d;
    logic             tick;
    logic             mode_rise;
    logic             inc_rise;

    always_comb begin
        // Button history follows the pins regardless of ena so a press made
        // while frozen is not mistaken for a fresh edge later.
        btn_mode_d = bus.btn_mode;
        btn_inc_d  = bus.btn_inc;
        mode_rise  = bus.btn_mode & ~btn_mode_q;
        inc_rise   = bus.btn_inc & ~btn_inc_q;
        tick       = (presc_q == PRESC_MAX);

        mode_d     = mode_q;
        presc_d    = presc_q;
        en_sec_u_d = 1'b0;
        en_sec_t_d = 1'b0;
        en_min_u_d = 1'b0;
        en_min_t_d = 1'b0;
        en_hr_d    = 1'b0;
        clr_sec_d  = 1'b0;

        if (bus.ena) begin
            case (mode_q)
                RUN: begin
                    presc_d    = tick ? '0 : presc_q + 1'b1;
                    en_sec_u_d = tick;
                    en_sec_t_d = tick & bus.max_sec_u;
                    en_min_u_d = en_sec_t_d & bus.max_sec_t;
                    en_min_t_d = en_min_u_d & bus.max_min_u;
                    en_hr_d    = en_min_t_d & bus.max_min_t;
                    // A coincident tick still goes out; the counters let clr win.
                    if (mode_rise) begin
                        mode_d    = SET_MIN;
                        clr_sec_d = 1'b1;
                        presc_d   = '0;
                    end
                end
                SET_MIN: begin
                    presc_d = '0;
                    if (mode_rise) begin
                        mode_d = SET_HR;
                    end else if (inc_rise) begin
                        en_min_u_d = 1'b1;
                        en_min_t_d = bus.max_min_u;
                    end
                end
                SET_HR: begin
                    presc_d = '0;
                    if (mode_rise) begin
                        mode_d = RUN;
                    end else if (inc_rise) begin
                        en_hr_d = 1'b1;
                    end
                end
                default: begin
                    mode_d  = RUN;
                    presc_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            mode_q     <= RUN;
            presc_q    <= '0;
            btn_mode_q <= 1'b0;
            btn_inc_q  <= 1'b0;
            en_sec_u_q <= 1'b0;
            en_sec_t_q <= 1'b0;
            en_min_u_q <= 1'b0;
            en_min_t_q <= 1'b0;
            en_hr_q    <= 1'b0;
            clr_sec_q  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            presc_q    <= presc_d;
            btn_mode_q <= btn_mode_d;
            btn_inc_q  <= btn_inc_d;
            en_sec_u_q <= en_sec_u_d;
            en_sec_t_q <= en_sec_t_d;
            en_min_u_q <= en_min_u_d;
            en_min_t_q <= en_min_t_d;
            en_hr_q    <= en_hr_d;
            clr_sec_q  <= clr_sec_d;
        end
    end

    assign bus.en_sec_u = en_sec_u_q;
    assign bus.en_sec_t = en_sec_t_q;
    assign bus.en_min_u = en_min_u_q;
    assign bus.en_min_t = en_min_t_q;
    assign bus.en_hr    = en_hr_q;
    assign bus.clr_sec  = clr_sec_q;
    assign bus.mode     = mode_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// Bench for clock_sequencer with CLK_DIV=4 and a BCD counter model feeding the max flags.
module tb_clock_sequencer;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    clock_sequencer_if sif ();

    clock_sequencer #(.CLK_DIV(4), .DIV_W(2)) dut (
        .clk (clk),
        .res (res),
        .bus (sif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    int base;
    int tb_mode;
    int p;

    always @(posedge clk or negedge res) begin
        if (!res) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // BCD counter model, advanced by the strobes the DUT issues
    int   m_su, m_st, m_mu, m_mt, m_hr;
    logic pre_req;
    int   pre_hr, pre_min, pre_sec;

    always @(posedge clk) begin
        if (pre_req) begin
            m_hr <= pre_hr;
            m_mt <= pre_min / 10;
            m_mu <= pre_min % 10;
            m_st <= pre_sec / 10;
            m_su <= pre_sec % 10;
        end else begin
            if (sif.clr_sec) begin
                m_su <= 0;
                m_st <= 0;
            end else begin
                if (sif.en_sec_u) m_su <= (m_su == 9) ? 0 : m_su + 1;
                if (sif.en_sec_t) m_st <= (m_st == 5) ? 0 : m_st + 1;
            end
            if (sif.en_min_u) m_mu <= (m_mu == 9) ? 0 : m_mu + 1;
            if (sif.en_min_t) m_mt <= (m_mt == 5) ? 0 : m_mt + 1;
            if (sif.en_hr)    m_hr <= (m_hr == 23) ? 0 : m_hr + 1;
        end
    end

    logic       use_tbl;
    logic [3:0] tbl_max;
    assign sif.max_sec_u = use_tbl ? tbl_max[0] : (m_su == 9);
    assign sif.max_sec_t = use_tbl ? tbl_max[1] : (m_st == 5);
    assign sif.max_min_u = use_tbl ? tbl_max[2] : (m_mu == 9);
    assign sif.max_min_t = use_tbl ? tbl_max[3] : (m_mt == 5);

    // Scoreboard of expected strobe words {clr, hr, min_t, min_u, sec_t, sec_u}
    typedef struct {
        int         cyc;
        logic [5:0] val;
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        logic [3:0] mx;
        logic [4:0] exp;
    } vec_t;
    vec_t tbl[8];

    logic mon_en;

    function automatic logic [5:0] obs();
        return {sif.clr_sec, sif.en_hr, sif.en_min_t, sif.en_min_u, sif.en_sec_t, sif.en_sec_u};
    endfunction

    function automatic logic [5:0] exp_run();
        logic su, st, mu, mt, hr;
        su = 1'b1;
        st = su & sif.max_sec_u;
        mu = st & sif.max_sec_t;
        mt = mu & sif.max_min_u;
        hr = mt & sif.max_min_t;
        return {1'b0, hr, mt, mu, st, su};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [5:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL strobe_missed: nothing compared at cycle %0d, required %b",
                         exp_q[0].cyc, exp_q[0].val);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                check($sformatf("strobes@%0d", cyc), 32'(obs()), 32'(exp_q[0].val));
                void'(exp_q.pop_front());
            end else if (obs() != 6'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got %b at cycle %0d, required 000000", obs(), cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (((cyc - base) % 4) == 3) push(cyc + 1, exp_run());
            step();
        end
    endtask

    task automatic press_inc(input int hold);
        sif.btn_inc = 1'b1;
        if (tb_mode == 1)      push(cyc + 1, {2'b00, sif.max_min_u, 1'b1, 2'b00});
        else if (tb_mode == 2) push(cyc + 1, 6'b010000);
        repeat (hold) step();
        sif.btn_inc = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at time limit, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0000, 5'b00001};
        tbl[1] = '{4'b0001, 5'b00011};
        tbl[2] = '{4'b0011, 5'b00111};
        tbl[3] = '{4'b0111, 5'b01111};
        tbl[4] = '{4'b1111, 5'b11111};
        tbl[5] = '{4'b1101, 5'b00011};
        tbl[6] = '{4'b1011, 5'b00111};
        tbl[7] = '{4'b1110, 5'b00001};

        res          = 1'b0;
        mon_en       = 1'b0;
        use_tbl      = 1'b0;
        tbl_max      = 4'b0;
        sif.ena      = 1'b0;
        sif.btn_mode = 1'b0;
        sif.btn_inc  = 1'b0;
        pre_req      = 1'b1;
        pre_hr       = 0;
        pre_min      = 0;
        pre_sec      = 0;
        tb_mode      = 0;
        base         = 0;
        repeat (3) step();
        pre_req = 1'b0;
        check("reset_strobes", 32'(obs()), 32'd0);
        check("reset_mode", 32'(sif.mode), 32'd0);

        // 1: free run from reset release (cycle 0)
        res     = 1'b1;
        sif.ena = 1'b1;
        mon_en  = 1'b1;
        push(4, 6'b000001);
        push(8, 6'b000001);
        goto_cyc(8);
        check("t1_mode", 32'(sif.mode), 32'd0);

        // Carry-ripple table with forced max flags
        use_tbl = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tbl_max = tbl[i].mx;
            while (((cyc - base) % 4) != 3) step();
            push(cyc + 1, {1'b0, tbl[i].exp});
            step();
        end
        use_tbl = 1'b0;

        // 2: 00:59:59 rolls over to 01:00:00
        step();
        pre_hr = 0; pre_min = 59; pre_sec = 59; pre_req = 1'b1;
        step();
        pre_req = 1'b0;
        step();
        push(cyc + 1, 6'b011111);
        step();
        step();
        check("t2_hr", 32'(m_hr), 32'd1);
        check("t2_min_t", 32'(m_mt), 32'd0);
        check("t2_min_u", 32'(m_mu), 32'd0);
        check("t2_sec_t", 32'(m_st), 32'd0);
        check("t2_sec_u", 32'(m_su), 32'd0);

        // 3: mode press coinciding with a tick, then 12 minute increments
        pre_hr = 5; pre_min = 58; pre_sec = 0; pre_req = 1'b1;
        step();
        pre_req = 1'b0;
        step();
        sif.btn_mode = 1'b1;
        push(cyc + 1, 6'b100001);
        step();
        tb_mode = 1;
        check("t3_mode", 32'(sif.mode), 32'd1);
        repeat (2) step();
        sif.btn_mode = 1'b0;
        repeat (20) step();
        for (int i = 0; i < 12; i++) press_inc(1);
        check("t3_min", 32'(m_mt * 10 + m_mu), 32'd10);
        check("t3_hr", 32'(m_hr), 32'd5);
        check("t3_sec", 32'(m_st * 10 + m_su), 32'd0);

        // 4: SET_HR increments with long holds, then back to RUN
        sif.btn_mode = 1'b1;
        step();
        tb_mode = 2;
        check("t4_mode_hr", 32'(sif.mode), 32'd2);
        sif.btn_mode = 1'b0;
        step();
        for (int i = 0; i < 3; i++) press_inc(5);
        check("t4_hr", 32'(m_hr), 32'd8);
        check("t4_min", 32'(m_mt * 10 + m_mu), 32'd10);
        sif.btn_mode = 1'b1;
        p = cyc;
        push(p + 5, 6'b000001);
        step();
        tb_mode = 0;
        check("t4_mode_run", 32'(sif.mode), 32'd0);
        sif.btn_mode = 1'b0;
        goto_cyc(p + 6);
        base = p + 1;

        // 5: simultaneous mode and inc edges in SET_MIN
        sif.btn_mode = 1'b1;
        push(cyc + 1, 6'b100000);
        step();
        sif.btn_mode = 1'b0;
        step();
        tb_mode = 1;
        check("t5_mode_min", 32'(sif.mode), 32'd1);
        sif.btn_mode = 1'b1;
        sif.btn_inc  = 1'b1;
        step();
        check("t5_mode_hr", 32'(sif.mode), 32'd2);
        sif.btn_mode = 1'b0;
        sif.btn_inc  = 1'b0;
        repeat (3) step();
        tb_mode = 2;

        // 6: freeze with ena=0 mid-count, then reset during SET_HR
        sif.btn_mode = 1'b1;
        step();
        base    = cyc;
        tb_mode = 0;
        sif.btn_mode = 1'b0;
        repeat (2) step();
        sif.ena = 1'b0;
        repeat (3) step();
        sif.btn_mode = 1'b1;
        repeat (7) step();
        sif.ena = 1'b1;
        base = base + 10;
        run_cycles(6);
        check("t6_edge_lost_while_frozen", 32'(sif.mode), 32'd0);
        sif.btn_mode = 1'b0;
        step();
        sif.btn_mode = 1'b1;
        push(cyc + 1, 6'b100000);
        step();
        sif.btn_mode = 1'b0;
        step();
        sif.btn_mode = 1'b1;
        step();
        sif.btn_mode = 1'b0;
        step();
        check("t6_mode_hr", 32'(sif.mode), 32'd2);
        mon_en = 1'b0;
        sif.btn_inc = 1'b1;
        step();
        check("t6_en_hr_before_reset", 32'(obs()), 32'h10);
        res = 1'b0;
        #1;
        check("t6_reset_strobes", 32'(obs()), 32'd0);
        check("t6_reset_mode", 32'(sif.mode), 32'd0);
        sif.btn_inc = 1'b0;
        repeat (2) step();
        res = 1'b1;
        repeat (2) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
